// File: rtl/multi_blinker.sv
// Multi-channel programmable blinker: CHANNELS square waves whose half-periods are
// BASE beats times a one-hot rate, with button-driven rate stepping on the selected channel.
module multi_blinker #(
  parameter int CHANNELS  = 4,
  parameter int RATE_W    = 4,
  parameter int BASE      = 32,
  parameter int FAST_LEFT = 0,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                count_en,
  input  logic [SEL_W-1:0]    sel,
  input  logic                shift_left,
  input  logic                shift_right,
  input  logic                sync_all,
  output logic [CHANNELS-1:0] switch,
  output logic [RATE_W-1:0]   rate_out
);

  localparam int MAX_H = BASE * (1 << (RATE_W - 1));
  localparam int CNT_W = (MAX_H > 1) ? $clog2(MAX_H) : 1;

  logic [RATE_W-1:0]   r_rate [CHANNELS];
  logic [CNT_W-1:0]    r_cnt  [CHANNELS];
  logic [CHANNELS-1:0] r_sw;
  logic                r_prev_l;
  logic                r_prev_r;

  logic                w_edge_l;
  logic                w_edge_r;
  logic                w_slower;
  logic                w_faster;
  logic [RATE_W-1:0]   w_rate_nxt [CHANNELS];
  logic [CHANNELS-1:0] w_chg;

  // Last count value of a half-period; rate is one-hot so BASE*rate-1 always fits CNT_W.
  function automatic logic [CNT_W-1:0] term_count(input logic [RATE_W-1:0] rate);
    int h;
    h = BASE * int'(rate);
    return CNT_W'(h - 1);
  endfunction

  function automatic logic [RATE_W-1:0] step_rate(input logic [RATE_W-1:0] rate,
                                                  input logic slower,
                                                  input logic faster);
    logic [RATE_W-1:0] nxt;
    nxt = rate;
    if (slower && !faster && !rate[RATE_W-1]) begin
      nxt = rate << 1;
    end else if (faster && !slower && !rate[0]) begin
      nxt = rate >> 1;
    end
    return nxt;
  endfunction

  assign w_edge_l = shift_left & ~r_prev_l;
  assign w_edge_r = shift_right & ~r_prev_r;
  assign w_slower = (FAST_LEFT != 0) ? w_edge_r : w_edge_l;
  assign w_faster = (FAST_LEFT != 0) ? w_edge_l : w_edge_r;

  // Only the selected channel sees a step; a saturated step is not a change.
  always_comb begin
    w_chg = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_rate_nxt[i] = r_rate[i];
      if (sel == SEL_W'(i)) begin
        w_rate_nxt[i] = step_rate(r_rate[i], w_slower, w_faster);
      end
      w_chg[i] = (w_rate_nxt[i] != r_rate[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_l <= 1'b1;
      r_prev_r <= 1'b1;
      r_sw     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_rate[i] <= RATE_W'(1);
        r_cnt[i]  <= '0;
      end
    end else begin
      r_prev_l <= shift_left;
      r_prev_r <= shift_right;
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_chg[i]) begin
          r_rate[i] <= w_rate_nxt[i];
        end
        // sync_all wins over counting; a rate change restarts the phase but keeps the level.
        if (sync_all) begin
          r_cnt[i] <= '0;
          r_sw[i]  <= 1'b0;
        end else if (w_chg[i]) begin
          r_cnt[i] <= '0;
        end else if (count_en) begin
          if (r_cnt[i] == term_count(r_rate[i])) begin
            r_cnt[i] <= '0;
            r_sw[i]  <= ~r_sw[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign switch = r_sw;

  always_comb begin
    rate_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i)) begin
        rate_out = r_rate[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_blinker.sv
// Randomised and directed bench for multi_blinker against a beat-counting reference model;
// two instances share stimulus: 4 channels FAST_LEFT=0, and 3 channels FAST_LEFT=1.
module tb_multi_blinker;

  localparam int BASE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       count_en;
  logic [1:0] sel;
  logic       shift_left;
  logic       shift_right;
  logic       sync_all;
  logic [3:0] sw0;
  logic [3:0] ro0;
  logic [2:0] sw1;
  logic [3:0] ro1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_blinker #(.CHANNELS(4), .RATE_W(4), .BASE(BASE), .FAST_LEFT(0)) dut0 (
    .clk(clk), .rst(rst), .count_en(count_en), .sel(sel),
    .shift_left(shift_left), .shift_right(shift_right), .sync_all(sync_all),
    .switch(sw0), .rate_out(ro0)
  );

  multi_blinker #(.CHANNELS(3), .RATE_W(4), .BASE(BASE), .FAST_LEFT(1)) dut1 (
    .clk(clk), .rst(rst), .count_en(count_en), .sel(sel),
    .shift_left(shift_left), .shift_right(shift_right), .sync_all(sync_all),
    .switch(sw1), .rate_out(ro1)
  );

  // Reference: rate held as exponent, phase as beats elapsed since last toggle/clear.
  int nch[2] = '{4, 3};
  int fl[2]  = '{0, 1};
  int m_e[2][4];
  int m_b[2][4];
  bit m_sw[2][4];
  bit m_pl;
  bit m_pr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        m_e[d][c]  = 0;
        m_b[d][c]  = 0;
        m_sw[d][c] = 1'b0;
      end
    m_pl = 1'b1;
    m_pr = 1'b1;
  endtask

  task automatic model_step();
    bit el, er, slow, chg;
    int s, ne;
    el = shift_left && !m_pl;
    er = shift_right && !m_pr;
    m_pl = shift_left;
    m_pr = shift_right;
    s = int'(sel);
    for (int d = 0; d < 2; d++) begin
      chg = 1'b0;
      if ((el ^ er) && s < nch[d]) begin
        slow = (fl[d] != 0) ? er : el;
        ne = m_e[d][s] + (slow ? 1 : -1);
        if (ne < 0) ne = 0;
        if (ne > 3) ne = 3;
        chg = (ne != m_e[d][s]);
        m_e[d][s] = ne;
      end
      for (int c = 0; c < nch[d]; c++) begin
        if (sync_all) begin
          m_b[d][c]  = 0;
          m_sw[d][c] = 1'b0;
        end else if (chg && c == s) begin
          m_b[d][c] = 0;
        end else if (count_en) begin
          m_b[d][c]++;
          if (m_b[d][c] == (BASE << m_e[d][c])) begin
            m_b[d][c]  = 0;
            m_sw[d][c] = ~m_sw[d][c];
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_sw(input int d);
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < nch[d]; c++) v[c] = m_sw[d][c];
    return v;
  endfunction

  function automatic logic [31:0] exp_ro(input int d);
    if (int'(sel) < nch[d]) return 32'(1) << m_e[d][int'(sel)];
    return '0;
  endfunction

  task automatic check_outputs();
    check_eq("sw0", 32'(sw0), exp_sw(0));
    check_eq("ro0", 32'(ro0), exp_ro(0));
    check_eq("sw1", 32'(sw1), exp_sw(1));
    check_eq("ro1", 32'(ro1), exp_ro(1));
  endtask

  // Called at a negedge: drive, clock, update model, compare on the next negedge.
  task automatic cyc(input bit en, input logic [1:0] s, input bit l, input bit r, input bit sy);
    count_en    = en;
    sel         = s;
    shift_left  = l;
    shift_right = r;
    sync_all    = sy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic press(input logic [1:0] s, input bit l, input bit r, input int hold);
    repeat (hold) cyc(1'b1, s, l, r, 1'b0);
    repeat (3) cyc(1'b1, s, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input bit hold_l, input logic [1:0] s);
    rst         = 1'b0;
    count_en    = 1'b1;
    sel         = s;
    shift_left  = hold_l;
    shift_right = 1'b0;
    sync_all    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    count_en = 1'b0; sel = 2'd0; shift_left = 1'b0; shift_right = 1'b0; sync_all = 1'b0;
    @(negedge clk);

    // Reset values, including out-of-range sel on the 3-channel instance.
    do_reset(1'b0, 2'd3);
    check_eq("rst_ro0", 32'(ro0), 32'd1);
    check_eq("rst_ro1_oor", 32'(ro1), 32'd0);
    check_eq("rst_sw0", 32'(sw0), 32'd0);

    repeat (40) cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("idle_ro0", 32'(ro0), 32'd1);

    // Slow down channel 1 to saturation.
    press(2'd1, 1'b1, 1'b0, 100); check_eq("slow1", 32'(ro0), 32'h2);
    press(2'd1, 1'b1, 1'b0, 100); check_eq("slow2", 32'(ro0), 32'h4);
    press(2'd1, 1'b1, 1'b0, 100); check_eq("slow3", 32'(ro0), 32'h8);
    press(2'd1, 1'b1, 1'b0, 100); check_eq("slow4_sat", 32'(ro0), 32'h8);
    repeat (70) cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);

    // Speed back up to the LSB boundary.
    press(2'd1, 1'b0, 1'b1, 5); check_eq("fast1", 32'(ro0), 32'h4);
    press(2'd1, 1'b0, 1'b1, 5); check_eq("fast2", 32'(ro0), 32'h2);
    press(2'd1, 1'b0, 1'b1, 5); check_eq("fast3", 32'(ro0), 32'h1);
    press(2'd1, 1'b0, 1'b1, 5); check_eq("fast4_sat", 32'(ro0), 32'h1);

    // Polarity on the FAST_LEFT=1 instance, channel 0.
    press(2'd0, 1'b1, 1'b0, 4); check_eq("pol_left_sat", 32'(ro1), 32'h1);
    press(2'd0, 1'b0, 1'b1, 4); check_eq("pol_right", 32'(ro1), 32'h2);

    // Simultaneous edges on channel 2.
    press(2'd2, 1'b1, 1'b1, 6); check_eq("simul_ro0", 32'(ro0), 32'h1);
    check_eq("simul_ro1", 32'(ro1), 32'h1);

    // Button held across reset release.
    @(negedge clk);
    do_reset(1'b1, 2'd2);
    repeat (10) cyc(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    check_eq("held_rst", 32'(ro0), 32'h1);
    repeat (3) cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);

    // Rates 1,2,4,8, then sync_all mid-period.
    press(2'd1, 1'b1, 1'b0, 2);
    repeat (2) press(2'd2, 1'b1, 1'b0, 2);
    repeat (3) press(2'd3, 1'b1, 1'b0, 2);
    repeat (13) cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    check_eq("sync_sw0", 32'(sw0), 32'd0);
    repeat (40) cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      cyc(1'b0, 2'(s), 1'b0, 1'b0, 1'b0);
      check_eq("keep_ro0", 32'(ro0), 32'(1) << s);
    end

    // Randomised traffic.
    begin
      bit l, r;
      logic [1:0] s;
      l = 1'b0; r = 1'b0; s = 2'd0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(19) == 0) l = ~l;
        if ($urandom_range(19) == 0) r = ~r;
        if ($urandom_range(9) == 0) s = 2'($urandom_range(3));
        cyc(1'($urandom_range(1)), s, l, r, ($urandom_range(199) == 0));
      end
    end

    // Asynchronous reset between clock edges.
    #2 rst = 1'b0;
    #1 model_reset();
    check_outputs();
    check_eq("async_sw0", 32'(sw0), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_blinker.md
# multi_blinker

Multi-channel, parameterised successor to the single programmable blinker. It drives CHANNELS independent square-wave outputs. Each output's half-period is a one-hot power-of-two multiple of BASE `count_en` beats, and the beats come from the shared beat32 tick. Debounced front-panel buttons adjust the rate of one channel at a time, selected by `sel`, with direction polarity set by parameter. The block sits between beat32 and the LED/switch outputs.

## Interface
- CHANNELS, 4, number of independent blink channels (1..16)
- RATE_W, 4, width of each channel's one-hot rate register; rates 1,2,4..2^(RATE_W-1)
- BASE, 32, `count_en` beats per unit half-period (32 = 1 s with beat32)
- FAST_LEFT, 0, 0: `shift_left` doubles the half-period (slower); 1: `shift_left` halves it (faster)
- clk  in  1  system clock; sole clock
- rst  in  1  asynchronous, active-low reset
- count_en  in  1  one-cycle beat strobe from beat32
- sel  in  max(1,$clog2(CHANNELS))  channel targeted by shift buttons; values >= CHANNELS select nothing
- shift_left  in  1  level button, synchronous, debounced upstream
- shift_right  in  1  level button, synchronous, debounced upstream
- sync_all  in  1  level; restarts every channel phase-aligned
- switch  out  CHANNELS  blink outputs, bit i = channel i, registered
- rate_out  out  RATE_W  one-hot rate register of channel `sel`; 0 if `sel` is out of range

## Operation
- Per channel i: one-hot `rate[i]`, phase counter `cnt[i]` of width $clog2(BASE*2^(RATE_W-1)), and `switch[i]`.
- Half-period for channel i: H = BASE * rate[i] beats (rate read as an integer). The full period is 2H.
- On each cycle with `count_en`=1:
  - If cnt[i] == H-1: cnt[i] <= 0 and switch[i] toggles.
  - Otherwise cnt[i] increments.
- Button edge detect: registers prev_l and prev_r. Edge = button & ~prev.
  - prev_l and prev_r reset to 1, so a button held across reset release produces no edge.
  - One press produces exactly one step, regardless of hold length.
- Step direction:
  - "Slower" = rate shift left by one; saturates at MSB, no change.
  - "Faster" = rate shift right by one; saturates at LSB, no change.
  - FAST_LEFT=0: shift_left is slower and shift_right is faster. FAST_LEFT=1: swapped.
- Simultaneous left and right edges in the same cycle: both ignored, no change.
- Any step that actually changes rate[sel] also clears cnt[sel] to 0 in the same cycle. switch[sel] holds its value.
  - A saturated (no-op) step leaves cnt untouched.
- Unselected channels are never affected by buttons.
- sync_all=1 in a cycle: all cnt <= 0 and all switch <= 0. This has priority over `count_en` counting. Rates are preserved.
  - A rate step in the same cycle as sync_all still updates rate.
- `sel` changing while a button is held: no new edge, so no step on the new channel.

## Timing
- Reset (rst=0, asynchronous):
  - rate[i] = 1 (LSB) for every channel.
  - cnt[i] = 0, switch = 0, prev_l = prev_r = 1.
  - rate_out = 1 if `sel` is in range, else 0.
- Reset deassertion is synchronised upstream. Reset asserted mid-period clears state immediately, without waiting for a clock.
- Toggle latency: switch[i] changes at the clock edge that samples the H-th `count_en` since the last toggle or clear, and is visible the following cycle.
- After reset, the first rise of switch[i] occurs on beat H. Steady state is H beats high, H beats low.
- Button latency: rate[sel] and rate_out update at the first clock edge that samples the button high, so they are visible one cycle after the button rises.
- A rate change takes effect immediately: the next toggle of that channel occurs H_new beats after the change.
- rate_out is combinational from `sel` and the rate registers.
- All outputs are glitch-free registered values, except rate_out.

## Test plan
- Reset/idle, BASE=2, CHANNELS=4: release rst, 40 count_en pulses -> all switch bits toggle every 2 beats in phase; rate_out=4'b0001.
- Saturating slow-down, FAST_LEFT=0, sel=1: four shift_left presses, each held 100 cycles -> rate_out goes 0010, 0100, 1000, 1000; switch[1] half-period becomes 16 beats; channels 0, 2 and 3 are unchanged at 2 beats.
- Speed-up to boundary, sel=1 at rate 1000: shift_right x4 -> rate_out 0100, 0010, 0001, 0001; cnt[1] cleared on the first three steps only.
- Polarity, FAST_LEFT=1 instance, sel=0: one shift_left from reset -> rate stays 0001 (saturated); one shift_right -> 0010.
- Simultaneous and held-through-reset, sel=2: shift_left and shift_right rise in the same cycle -> no change; button held during reset release -> no step.
- sync_all mid-period with channels at rates 1, 2, 4, 8 -> all switch bits go to 0 the next cycle; each channel's first rise then occurs at exactly BASE*rate beats; rates are retained.
